// File: rtl/cmp_stream_pkg.sv
// Shared types for the streaming comparator: one-hot result encoding, handshake state, counter helper.
package cmp_pkg;

  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_LT   = 3'b001,
    CMP_EQ   = 3'b010,
    CMP_GT   = 3'b100
  } cmp_res_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cmp_state_e;

  // Widest statistics counter the helper below can serve.
  localparam int CMP_CNT_MAX_W = 64;

  // Saturating increment; callers zero-extend their counter and its all-ones limit.
  function automatic logic [CMP_CNT_MAX_W-1:0] cmp_sat_inc(
    input logic [CMP_CNT_MAX_W-1:0] cnt,
    input logic [CMP_CNT_MAX_W-1:0] max_val
  );
    return (cnt >= max_val) ? max_val : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/cmp_stream_if.sv
// Operand/result stream of the comparator; master drives operands and out_ready, slave is the comparator.
interface cmp_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             a_greater_b;
  logic             a_equal_b;
  logic             a_less_b;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, a_greater_b, a_equal_b, a_less_b
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, a_greater_b, a_equal_b, a_less_b
  );
endinterface

// File: rtl/cmp_stream_core.sv
// Combinational signed/unsigned magnitude compare producing a one-hot result; no latency, no handshake.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_e         res
);

  if (WIDTH < 1) begin : g_width_chk
    $error("cmp_core: WIDTH must be at least 1");
  end

  always_comb begin
    res = CMP_EQ;
    if (signed_mode) begin
      // For WIDTH=1 the lone bit is the sign, so 1'b1 reads as -1.
      if ($signed(a) > $signed(b)) begin
        res = CMP_GT;
      end else if ($signed(a) < $signed(b)) begin
        res = CMP_LT;
      end
    end else begin
      if (a > b) begin
        res = CMP_GT;
      end else if (a < b) begin
        res = CMP_LT;
      end
    end
  end

endmodule

// File: rtl/cmp_stream.sv
// Streaming comparator: one registered result slot, latency 1 clk, in_ready = !out_valid || out_ready.
// Optional saturating per-outcome transfer counters when CMP_STATS_EN is defined.
module cmp_stream
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_stream_if.slave      bus
`ifdef CMP_STATS_EN
  ,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
`endif
);

  if (CNT_W < 1 || CNT_W > CMP_CNT_MAX_W) begin : g_cnt_w_chk
    $error("cmp_stream: CNT_W out of range");
  end

  cmp_state_e state;
  cmp_res_e   res_q;
  cmp_res_e   res_c;

  cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a           (bus.a),
    .b           (bus.b),
    .signed_mode (bus.signed_mode),
    .res         (res_c)
  );

  assign bus.out_valid   = (state == ST_FULL);
  assign bus.in_ready    = (state == ST_EMPTY) || bus.out_ready;
  assign bus.a_greater_b = res_q[2];
  assign bus.a_equal_b   = res_q[1];
  assign bus.a_less_b    = res_q[0];

  // res_q drops to CMP_NONE whenever the slot empties, so flags read 000 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      res_q <= CMP_NONE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            state <= ST_FULL;
            res_q <= res_c;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              res_q <= res_c;
            end else begin
              state <= ST_EMPTY;
              res_q <= CMP_NONE;
            end
          end
        end
        default: begin
          state <= ST_EMPTY;
          res_q <= CMP_NONE;
        end
      endcase
    end
  end

`ifdef CMP_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic xfer;
  assign xfer = bus.out_valid && bus.out_ready;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return CNT_W'(cmp_sat_inc(CMP_CNT_MAX_W'(c), CMP_CNT_MAX_W'(CNT_MAX)));
  endfunction

  // A clear beats a same-cycle transfer: the counters land on zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (clr_stats) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (xfer) begin
      case (res_q)
        CMP_GT:  cnt_gt <= bump(cnt_gt);
        CMP_EQ:  cnt_eq <= bump(cnt_eq);
        CMP_LT:  cnt_lt <= bump(cnt_lt);
        default: ;
      endcase
    end
  end
`endif

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> $onehot({bus.a_greater_b, bus.a_equal_b, bus.a_less_b}));

  a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.out_valid |-> ({bus.a_greater_b, bus.a_equal_b, bus.a_less_b} == 3'b000));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(res_q)));

endmodule

// File: tb/tb_cmp_stream.sv
// Scoreboarded directed bench for cmp_stream (WIDTH=8, CNT_W=2); counter checks need CMP_STATS_EN.
module tb_cmp_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef CMP_STATS_EN
  logic             clr_stats;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_lt;
`endif

  cmp_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef CMP_STATS_EN
    ,
    .clr_stats (clr_stats),
    .cnt_gt    (cnt_gt),
    .cnt_eq    (cnt_eq),
    .cnt_lt    (cnt_lt)
`endif
  );

  int total  = 0;
  int passed = 0;
  logic [2:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] flags();
    return {bus.a_greater_b, bus.a_equal_b, bus.a_less_b};
  endfunction

  // Monitor: every delivered result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: result %0b delivered with nothing expected", flags());
      end else begin
        check("sb_result", 32'(flags()), 32'(sb.pop_front()));
      end
    end
  end

  // Presents one pair, waits (bounded) for acceptance, pushes the expected result.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sm, input logic [2:0] exp);
    bus.a           = av;
    bus.b           = bv;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    $display("FAIL send_timeout: pair %0h/%0h never accepted", av, bv);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b1;
`ifdef CMP_STATS_EN
    clr_stats       = 1'b0;
`endif

    // 1. reset state
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
`ifdef CMP_STATS_EN
    check("rst_counters", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // 2. unsigned vs signed, latency 1
    send(8'hF0, 8'h0F, 1'b0, R_GT);
    check("t2_uns_valid", 32'(bus.out_valid), 32'd1);
    check("t2_uns_flags", 32'(flags()), 32'(R_GT));
    send(8'hF0, 8'h0F, 1'b1, R_LT);
    check("t2_sgn_flags", 32'(flags()), 32'(R_LT));
    send(8'h80, 8'h7F, 1'b1, R_LT);
    send(8'h80, 8'h7F, 1'b0, R_GT);
    send(8'hFF, 8'h00, 1'b1, R_LT);
    drain();

    // 3. back-to-back eq then lt
    sb.push_back(R_EQ);
    sb.push_back(R_LT);
    bus.a = 8'h5A; bus.b = 8'h5A; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h01; bus.b = 8'h02;
    check("t3_first_valid", 32'(bus.out_valid), 32'd1);
    check("t3_first_flags", 32'(flags()), 32'(R_EQ));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t3_second_flags", 32'(flags()), 32'(R_LT));
    drain();
    check("t3_idle_valid", 32'(bus.out_valid), 32'd0);
    check("t3_idle_flags", 32'(flags()), 32'd0);

    // 4. backpressure
    bus.out_ready = 1'b0;
    send(8'h10, 8'h05, 1'b0, R_GT);
    bus.a = 8'h03; bus.b = 8'h04; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_flags", 32'(flags()), 32'(R_GT));
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    sb.push_back(R_LT);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t4_second_valid", 32'(bus.out_valid), 32'd1);
    check("t4_second_flags", 32'(flags()), 32'(R_LT));
    drain();

`ifdef CMP_STATS_EN
    // 5. saturating counters and clear priority
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    check("t5_cleared", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'd0);
    for (int i = 0; i < 5; i++) send(8'h20, 8'h10, 1'b0, R_GT);
    drain();
    check("t5_cnt_gt_sat", 32'(cnt_gt), 32'd3);
    check("t5_cnt_eq", 32'(cnt_eq), 32'd0);
    bus.out_ready = 1'b0;
    send(8'h33, 8'h33, 1'b0, R_EQ);
    bus.out_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    check("t5_clr_wins", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'd0);
    send(8'h44, 8'h44, 1'b1, R_EQ);
    drain();
    check("t5_cnt_eq_one", 32'(cnt_eq), 32'd1);
`endif

    // 6. reset mid-transaction under backpressure
    bus.out_ready = 1'b0;
    send(8'h7F, 8'h80, 1'b1, R_GT);
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_flags", 32'(flags()), 32'd0);
`ifdef CMP_STATS_EN
    check("t6_rst_counters", 32'({cnt_gt, cnt_eq, cnt_lt}), 32'd0);
`endif
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_idle_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(8'h00, 8'h00, 1'b0, R_EQ);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
